memory_cycle: RTL
=================

Name: memory_cycle

Overview:
- Memory stage of the 5-stage RISC-V pipeline; sits directly downstream of the execute stage and consumes its EX/MEM outputs.
- Performs loads and stores against an internal word-organised data memory, with byte/halfword/word access sizes selected by funct3.
- Sign- or zero-extends load data.
- Holds the MEM/WB pipeline register that feeds the writeback stage.

Parameters:
DEPTH, 1024, number of 32-bit words in data memory (power of two)
ADDR_W, 10, word-index width; must equal log2(DEPTH)

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
RegWrite_M  input  1  instruction writes register file
ResultSrc_M  input  2  writeback select: 00 ALU, 01 memory, 10 PC+4
MemWrite_M  input  1  instruction is a store
MemRead_M  input  1  instruction is a load
funct3_M  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
ALUResult_M  input  32  effective address / ALU result
WriteData_M  input  32  store data (rs2)
RD_M  input  5  destination register
PCPlus4_M  input  32  PC+4 of instruction
RegWrite_W  output  1  registered RegWrite
ResultSrc_W  output  2  registered ResultSrc
RD_W  output  5  registered destination
ALUResult_W  output  32  registered ALU result
ReadData_W  output  32  registered extended load data
PCPlus4_W  output  32  registered PC+4
Misaligned_W  output  1  registered misaligned-access flag

Behaviour:
- Reset: on a rising edge with rst=1, all *_W outputs clear to 0. Memory contents are not cleared, and no store commits on that edge, even if MemWrite_M=1.
- Latency: a single 1-cycle register stage. Values presented in cycle N appear on *_W after edge N+1.
- Word index: ALUResult_M[ADDR_W+1:2].
- Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Byte lane: ALUResult_M[1:0].
- Misaligned condition:
  - halfword (001/101) with addr[0]=1
  - word (010) with addr[1:0]!=00
  - funct3 values other than those listed, when MemRead_M or MemWrite_M is set
- Store (MemWrite_M=1, not misaligned, rst=0): write on the rising edge.
  - Byte: WriteData_M[7:0] into lane addr[1:0].
  - Halfword: WriteData_M[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - Word: full word.
  - Unwritten lanes are preserved.
- Store misaligned: the write is suppressed and memory is unchanged.
- Load: combinational read of the indexed word; the lane(s) selected by addr[1:0] are right-justified.
  - Extension: 000 sign-extends from bit 7, 001 from bit 15; 100/101 zero-extend; 010 passes the word.
  - The result registers into ReadData_W.
- Load misaligned: ReadData_W=0 and RegWrite_W is forced to 0, so the register file is not corrupted.
- Non-load cycles (MemRead_M=0): ReadData_W registers 0.
- Misaligned_W = misaligned AND (MemRead_M OR MemWrite_M). It is never set by non-memory instructions, whatever the address.
- Store at cycle N, load of the same word at N+1: the load returns the newly written data, because the write committed at the edge ending N.
- MemRead_M and MemWrite_M both 1: treated as a store. ReadData_W=0; RegWrite_W passes through unchanged.
- Reset asserted mid-sequence: an in-flight store on the reset edge is dropped and outputs clear. The pipeline resumes normally on the first edge with rst=0.
- No stall/flush inputs; this stage advances every cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with MemWrite_M=1, addr 0x10, data 0xDEADBEEF -> all *_W=0; a later lw 0x10 returns the prior contents (not DEADBEEF).
- Word round-trip: sw 0x12345678 @0x20, then lw @0x20 -> ReadData_W=0x12345678 one cycle after the load, RegWrite_W=1, ResultSrc_W=01.
- Sub-word store and extension:
  - Word @0x40 = 0x00000000.
  - sb 0x80 @0x41, sh 0xF00D @0x42.
  - lb @0x41 -> 0xFFFFFF80; lbu @0x41 -> 0x00000080; lh @0x42 -> 0xFFFFF00D; lw @0x40 -> 0xF00D8000.
- Misaligned:
  - sh @0x43 -> memory unchanged, Misaligned_W=1.
  - lw @0x22 with RegWrite_M=1 -> ReadData_W=0, RegWrite_W=0, Misaligned_W=1.
- Wrap-around (DEPTH=1024): sw 0xCAFEF00D @0x1004 then lw @0x4 -> 0xCAFEF00D.
- Passthrough: ALU op (MemRead/MemWrite=0), RD_M=5, ALUResult_M=0x7, PCPlus4_M=0x104, ResultSrc_M=10 -> next cycle RD_W=5, ALUResult_W=7, PCPlus4_W=0x104, ReadData_W=0, Misaligned_W=0.

Source files
------------

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - RISC-V pipeline memory stage with data memory and MEM/WB register
//
// Purpose: performs byte/halfword/word loads and stores against an internal
// word-organised data memory, extends load data, flags misaligned accesses
// and registers everything into the MEM/WB pipeline register.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   RegWrite_M          instruction writes the register file
//   ResultSrc_M[1:0]    writeback select (00 ALU, 01 memory, 10 PC+4)
//   MemWrite_M          store
//   MemRead_M           load
//   funct3_M[2:0]       access size/sign (b, h, w, bu, hu)
//   ALUResult_M[31:0]   effective address / ALU result
//   WriteData_M[31:0]   store data
//   RD_M[4:0]           destination register
//   PCPlus4_M[31:0]     PC+4
//   *_W                 registered MEM/WB copies, ReadData_W holds extended load data,
//                       Misaligned_W flags a misaligned memory access
module memory_cycle #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_M,
  input  logic [1:0]  ResultSrc_M,
  input  logic        MemWrite_M,
  input  logic        MemRead_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteData_M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4_M,
  output logic        RegWrite_W,
  output logic [1:0]  ResultSrc_W,
  output logic [4:0]  RD_W,
  output logic [31:0] ALUResult_W,
  output logic [31:0] ReadData_W,
  output logic [31:0] PCPlus4_W,
  output logic        Misaligned_W
);

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              misalign;
  logic              mem_access;
  logic              is_load;
  logic              store_en;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;

  logic        regwrite_d, regwrite_q;
  logic [1:0]  resultsrc_d, resultsrc_q;
  logic [4:0]  rd_d, rd_q;
  logic [31:0] aluresult_d, aluresult_q;
  logic [31:0] readdata_d, readdata_q;
  logic [31:0] pcplus4_d, pcplus4_q;
  logic        misaligned_d, misaligned_q;

  // Upper address bits are dropped, so accesses wrap modulo DEPTH*4 bytes.
  assign idx  = ALUResult_M[ADDR_W+1:2];
  assign lane = ALUResult_M[1:0];

  assign mem_access = MemRead_M | MemWrite_M;
  // A simultaneous read+write is handled as a store only.
  assign is_load    = MemRead_M & ~MemWrite_M;
  assign store_en   = MemWrite_M & ~misalign;

  // Alignment check; unknown funct3 encodings are treated as misaligned so
  // they can never commit a store or return load data.
  always_comb begin
    misalign = 1'b0;
    case (funct3_M)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = lane[0];
      3'b010:         misalign = (lane != 2'b00);
      default:        misalign = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b0000;
    wdata = WriteData_M;
    case (funct3_M[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{WriteData_M[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteData_M[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = WriteData_M;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Combinational read, selected lane(s) right-justified then extended.
  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = 32'h0;
    case (funct3_M)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_ext = rd_word;
      3'b100:  load_ext = {24'h0, rd_byte};
      3'b101:  load_ext = {16'h0, rd_half};
      default: load_ext = 32'h0;
    endcase
  end

  always_comb begin
    // A misaligned load must not write back, protecting the register file.
    regwrite_d   = RegWrite_M & ~(is_load & misalign);
    resultsrc_d  = ResultSrc_M;
    rd_d         = RD_M;
    aluresult_d  = ALUResult_M;
    pcplus4_d    = PCPlus4_M;
    readdata_d   = (is_load && !misalign) ? load_ext : 32'h0;
    misaligned_d = misalign & mem_access;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q   <= 1'b0;
      resultsrc_q  <= 2'b00;
      rd_q         <= 5'd0;
      aluresult_q  <= 32'h0;
      readdata_q   <= 32'h0;
      pcplus4_q    <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      regwrite_q   <= regwrite_d;
      resultsrc_q  <= resultsrc_d;
      rd_q         <= rd_d;
      aluresult_q  <= aluresult_d;
      readdata_q   <= readdata_d;
      pcplus4_q    <= pcplus4_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign RegWrite_W   = regwrite_q;
  assign ResultSrc_W  = resultsrc_q;
  assign RD_W         = rd_q;
  assign ALUResult_W  = aluresult_q;
  assign ReadData_W   = readdata_q;
  assign PCPlus4_W    = pcplus4_q;
  assign Misaligned_W = misaligned_q;

endmodule
